// File: rtl/adc_serial_pkg.sv
// Shared definitions for the serial ADC responder.
//   DATA_W_DEF      : default result width in bits
//   CONV_CYCLES_DEF : default conversion time in clk cycles (17 us at 50 MHz)
//   frame_state_t   : serial frame FSM states
//   conv_state_t    : converter FSM states
package adc_serial_pkg;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned CONV_CYCLES_DEF = 850;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } frame_state_t;

  typedef enum logic {
    READY = 1'b0,
    CONV  = 1'b1
  } conv_state_t;

endpackage

// File: rtl/adc_sync_edge.sv
// Multi-stage synchronizer with edge pulses on the synchronized copy.
//   clk, rst_n : system clock, synchronous active-low reset
//   din        : asynchronous input pin
//   rise, fall : one-cycle pulses on synchronized rising/falling edges
// RESET_VAL sets the assumed idle level so no spurious edge leaves reset.
module adc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q[0] <= din;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/adc_serial_responder.sv
// Converter-side model of the 3-wire serial ADC link.
//   clk, rst_n   : system clock, synchronous active-low reset
//   adc_cs_n     : chip-select from the reader (asynchronous)
//   adc_clk      : serial clock from the reader (asynchronous)
//   adc_data     : serial data, MSB first, shifted on adc_clk falling edges
//   adc_data_oe  : high while a frame is selected (tri-state enable model)
//   sample_in    : value latched when a conversion starts
//   result       : last completed conversion, shifted out by the next frame
//   conv_busy    : high while a conversion runs
//   frame_done   : one-cycle pulse on the final shifting edge of a frame
//   conv_err     : sticky, chip-select fell during a conversion
module adc_serial_responder
  import adc_serial_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned CONV_CYCLES = CONV_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adc_cs_n,
  input  logic              adc_clk,
  output logic              adc_data,
  output logic              adc_data_oe,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] result,
  output logic              conv_busy,
  output logic              frame_done,
  output logic              conv_err
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  logic cs_rise, cs_fall;
  logic sclk_fall, sclk_rise_unused;

  adc_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (adc_cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  adc_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (adc_clk),
    .rise  (sclk_rise_unused),
    .fall  (sclk_fall)
  );

  // Frame FSM. adc_data is the shift register MSB: zeros shift in behind
  // the data, so the line reads 0 in TAIL and IDLE without extra muxing.
  frame_state_t      frame_q, frame_nxt;
  logic [DATA_W-1:0] shift_q, shift_nxt;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_nxt;
  logic              oe_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      adc_data_oe <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_q     <= frame_nxt;
      shift_q     <= shift_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      adc_data_oe <= oe_nxt;
      frame_done  <= done_nxt;
    end
  end

  always_comb begin
    frame_nxt   = frame_q;
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt_q;
    oe_nxt      = adc_data_oe;
    done_nxt    = 1'b0;
    unique case (frame_q)
      IDLE: begin
        if (cs_fall) begin
          shift_nxt   = result;
          bit_cnt_nxt = '0;
          oe_nxt      = 1'b1;
          frame_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          shift_nxt = '0;
          oe_nxt    = 1'b0;
          frame_nxt = IDLE;
        end else if (sclk_fall) begin
          shift_nxt   = {shift_q[DATA_W-2:0], 1'b0};
          bit_cnt_nxt = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            shift_nxt = '0;
            done_nxt  = 1'b1;
            frame_nxt = TAIL;
          end
        end
      end
      TAIL: begin
        if (cs_rise) begin
          shift_nxt = '0;
          oe_nxt    = 1'b0;
          frame_nxt = IDLE;
        end
      end
      default: begin
        shift_nxt = '0;
        oe_nxt    = 1'b0;
        frame_nxt = IDLE;
      end
    endcase
  end

  assign adc_data = shift_q[DATA_W-1];

  // Converter FSM.
  conv_state_t       conv_q, conv_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [DATA_W-1:0] latch_q, latch_nxt;
  logic [DATA_W-1:0] result_nxt;
  logic              busy_nxt, err_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conv_q    <= READY;
      cnt_q     <= '0;
      latch_q   <= '0;
      result    <= '0;
      conv_busy <= 1'b0;
      conv_err  <= 1'b0;
    end else begin
      conv_q    <= conv_nxt;
      cnt_q     <= cnt_nxt;
      latch_q   <= latch_nxt;
      result    <= result_nxt;
      conv_busy <= busy_nxt;
      conv_err  <= err_nxt;
    end
  end

  always_comb begin
    conv_nxt   = conv_q;
    cnt_nxt    = cnt_q;
    latch_nxt  = latch_q;
    result_nxt = result;
    busy_nxt   = conv_busy;
    err_nxt    = conv_err | (cs_fall & conv_busy);
    unique case (conv_q)
      READY: begin
        if (frame_done) begin
          latch_nxt = sample_in;
          cnt_nxt   = CNT_LOAD;
          busy_nxt  = 1'b1;
          conv_nxt  = CONV;
        end
      end
      CONV: begin
        // frame_done here comes from an erroneous frame; it is ignored.
        if (cnt_q == '0) begin
          result_nxt = latch_q;
          busy_nxt   = 1'b0;
          conv_nxt   = READY;
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      default: begin
        busy_nxt = 1'b0;
        conv_nxt = READY;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Self-checking bench for adc_serial_responder: emulates the reader
// (12/13-cycle adc_clk phases) and checks against a frame/conversion model.
module tb_adc_serial_responder;

  localparam int unsigned DW    = 8;
  localparam int unsigned CONV  = 850;
  localparam int unsigned PH_HI = 12;
  localparam int unsigned PH_LO = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          adc_cs_n = 1'b1;
  logic          adc_clk = 1'b0;
  logic          adc_data, adc_data_oe;
  logic [DW-1:0] sample_in = '0;
  logic [DW-1:0] result;
  logic          conv_busy, frame_done, conv_err;

  int n_checks = 0;
  int n_fail   = 0;

  int   cyc = 0, fd_count = 0, busy_cycles = 0, fd_cyc = -1, rise_cyc = -1;
  logic busy_prev = 1'b0;
  logic [DW-1:0] model_result = '0;

  adc_serial_responder #(
    .DATA_W      (DW),
    .CONV_CYCLES (CONV),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_cs_n    (adc_cs_n),
    .adc_clk     (adc_clk),
    .adc_data    (adc_data),
    .adc_data_oe (adc_data_oe),
    .sample_in   (sample_in),
    .result      (result),
    .conv_busy   (conv_busy),
    .frame_done  (frame_done),
    .conv_err    (conv_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (frame_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
    if (conv_busy) busy_cycles++;
    if (conv_busy && !busy_prev) rise_cyc = cyc;
    busy_prev = conv_busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bits the reader should see: the current result MSB-first, then zeros.
  function automatic logic [11:0] expect_bits(input logic [DW-1:0] val, input int n);
    logic [11:0] b;
    logic        bit_v;
    b = '0;
    for (int i = 0; i < n; i++) begin
      if (i < DW) bit_v = val[DW-1-i];
      else        bit_v = 1'b0;
      b = {b[10:0], bit_v};
    end
    return b;
  endfunction

  // Reader emulation; called at a negedge. Samples adc_data late in each high phase.
  task automatic run_frame(input int n_pulses, output logic [11:0] bits);
    bits = '0;
    adc_cs_n = 1'b0;
    wait_neg(2);
    check("oe_lag_on", adc_data_oe, 0);
    wait_neg(1);
    check("oe_on", adc_data_oe, 1);
    wait_neg(10);
    for (int i = 0; i < n_pulses; i++) begin
      adc_clk = 1'b1;
      wait_neg(PH_HI);
      bits = {bits[10:0], adc_data};
      adc_clk = 1'b0;
      wait_neg(PH_LO);
    end
    adc_cs_n = 1'b1;
    wait_neg(2);
    check("oe_lag_off", adc_data_oe, 1);
    wait_neg(1);
    check("oe_off", adc_data_oe, 0);
    check("data_off", adc_data, 0);
    wait_neg(5);
  endtask

  task automatic frame_and_check(input string tag, input logic [DW-1:0] smp, input int n,
                                 input logic [11:0] exp_bits, input bit exp_done,
                                 input logic [DW-1:0] exp_result);
    logic [11:0] bits;
    sample_in   = smp;
    fd_count    = 0;
    busy_cycles = 0;
    fd_cyc      = -1;
    rise_cyc    = -1;
    run_frame(n, bits);
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_frame_done"}, fd_count, exp_done ? 1 : 0);
    for (int i = 0; i < 2 * CONV && conv_busy; i++) @(negedge clk);
    check({tag, "_conv_idle"}, conv_busy, 0);
    check({tag, "_busy_len"}, busy_cycles, exp_done ? CONV : 0);
    if (exp_done) check({tag, "_busy_lat"}, rise_cyc - fd_cyc, 1);
    check({tag, "_result"}, result, exp_result);
  endtask

  typedef struct {
    logic [DW-1:0] smp;
    int            n;
    logic [11:0]   exp_bits;
    bit            exp_done;
    logic [DW-1:0] exp_result;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [11:0]   bits;
    logic [DW-1:0] smp, er;
    int            n;
    bit            done;

    // Full frame from reset, second full frame, abort after 5, 12-pulse frame.
    vecs[0] = '{8'hA5, 8,  12'h000, 1'b1, 8'hA5};
    vecs[1] = '{8'h3C, 8,  12'h0A5, 1'b1, 8'h3C};
    vecs[2] = '{8'h77, 5,  12'h007, 1'b0, 8'h3C};
    vecs[3] = '{8'h77, 12, 12'h3C0, 1'b1, 8'h77};

    wait_neg(4);
    check("rst_data", adc_data, 0);
    check("rst_oe", adc_data_oe, 0);
    check("rst_result", result, 0);
    check("rst_busy", conv_busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", conv_err, 0);
    rst_n = 1'b1;
    wait_neg(4);

    for (int v = 0; v < 4; v++) begin
      frame_and_check($sformatf("vec%0d", v), vecs[v].smp, vecs[v].n,
                      vecs[v].exp_bits, vecs[v].exp_done, vecs[v].exp_result);
    end
    model_result = 8'h77;

    for (int r = 0; r < 8; r++) begin
      smp  = DW'($urandom);
      n    = $urandom_range(12, 1);
      done = (n >= DW);
      er   = done ? smp : model_result;
      frame_and_check($sformatf("rand%0d", r), smp, n, expect_bits(model_result, n), done, er);
      model_result = er;
    end

    // Frame started 100 cycles into a conversion.
    fd_count    = 0;
    busy_cycles = 0;
    sample_in   = 8'h5A;
    run_frame(8, bits);
    check("err_f1_bits", bits, expect_bits(model_result, 8));
    sample_in = 8'hC3;
    for (int i = 0; i < 2000 && busy_cycles < 100; i++) @(negedge clk);
    check("err_clear_before", conv_err, 0);
    check("err_busy_at_100", conv_busy, 1);
    run_frame(8, bits);
    check("err_f2_bits", bits, expect_bits(model_result, 8));
    check("err_set", conv_err, 1);
    check("err_fd_count", fd_count, 2);
    for (int i = 0; i < 2 * CONV && conv_busy; i++) @(negedge clk);
    check("err_busy_len", busy_cycles, CONV);
    check("err_result", result, 8'h5A);
    wait_neg(50);
    check("err_no_restart", conv_busy, 0);
    check("err_result_kept", result, 8'h5A);
    check("err_sticky", conv_err, 1);
    model_result = 8'h5A;

    // Reset in the middle of a conversion.
    frame_and_check("pre_rst", 8'h3C, 8, expect_bits(model_result, 8), 1'b1, 8'h3C);
    model_result = 8'h3C;
    sample_in = 8'hFF;
    run_frame(8, bits);
    check("rst_mid_bits", bits, expect_bits(model_result, 8));
    wait_neg(200);
    check("rst_mid_busy", conv_busy, 1);
    check("rst_mid_err_held", conv_err, 1);
    rst_n = 1'b0;
    wait_neg(1);
    check("rst_mid_data", adc_data, 0);
    check("rst_mid_oe", adc_data_oe, 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_busy0", conv_busy, 0);
    check("rst_mid_done", frame_done, 0);
    check("rst_mid_err", conv_err, 0);
    rst_n = 1'b1;
    wait_neg(CONV + 100);
    check("rst_no_stale_result", result, 0);
    check("rst_no_stale_busy", conv_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_serial_responder.md
# adc_serial_responder

Synthesizable responder for the 3-wire serial ADC link (chip-select, serial clock, serial data). It models the converter end: it shifts the previous conversion result out MSB-first while chip-select is low, then runs a fixed-length conversion on a parallel sample input. It stands in for the physical ADC in loopback builds and board-less regression, facing the existing ADC reader block pin-for-pin.

## Interface
Parameters:
- DATA_W, 8, result width in bits.
- CONV_CYCLES, 850, conversion time in clk cycles (17 us at 50 MHz).
- SYNC_STAGES, 2, synchronizer depth on adc_cs_n and adc_clk.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- adc_cs_n  in  1  chip-select from the reader, asynchronous to clk.
- adc_clk  in  1  serial clock from the reader, asynchronous to clk.
- adc_data  out  1  serial data to the reader, MSB first.
- adc_data_oe  out  1  high while a frame is selected; models the tri-state enable.
- sample_in  in  DATA_W  value converted at conversion start.
- result  out  DATA_W  last completed conversion; this is the value shifted out next.
- conv_busy  out  1  high during conversion.
- frame_done  out  1  one-cycle pulse on the 8th adc_clk falling edge.
- conv_err  out  1  sticky; set when adc_cs_n falls while conv_busy is high. Cleared only by reset.

## Operation
- adc_cs_n and adc_clk each pass through SYNC_STAGES flops. Edges are detected on the synchronized copies.
- Frame FSM:
  - IDLE: wait for a cs_n fall. On the fall, load the shift register from result, drive adc_data to result[DATA_W-1], assert adc_data_oe, clear the bit counter, and go to SHIFT.
  - SHIFT: on each adc_clk falling edge, shift left, increment the bit counter, and drive the next bit. adc_clk rising edges cause no action; the reader samples during the high phase.
    - On the DATA_W-th falling edge: pulse frame_done, drive adc_data 0, and go to TAIL.
  - TAIL: hold adc_data at 0. Further adc_clk edges are ignored.
  - From SHIFT or TAIL, a cs_n rise returns the FSM to IDLE and clears adc_data and adc_data_oe.
- Converter FSM:
  - READY: on frame_done, latch sample_in, load the counter with CONV_CYCLES-1, raise conv_busy, and go to CONV.
  - CONV: decrement the counter each cycle. At 0, write the latched value to result, drop conv_busy, and go to READY.
- Early cs_n rise in SHIFT (fewer than DATA_W falling edges): the frame is aborted, no conversion starts, and result is unchanged.
- cs_n fall during CONV: set conv_err. The frame still runs and shifts out the old result. The conversion continues unaffected.
- frame_done during CONV: impossible unless an erroneous frame completes during CONV. In that case the conversion is not restarted and sample_in is not relatched.
- A cs_n fall and a conversion completing in the same cycle: the shift register loads the old result, and result updates afterwards.

## Timing
- Reset values: adc_data 0, adc_data_oe 0, result 0, conv_busy 0, frame_done 0, conv_err 0. Both FSMs reset to IDLE/READY.
- Reset while in SHIFT or CONV: the frame and conversion are abandoned, with no result write.
- adc_data and adc_data_oe change SYNC_STAGES+1 clk cycles after the causing pin edge (3 cycles with defaults).
- conv_busy rises in the cycle after frame_done.
- result updates, and conv_busy falls, CONV_CYCLES cycles after conv_busy rises.
- Minimum adc_clk high or low time for correct edge detection: SYNC_STAGES+1 clk cycles. The reader's 12/13-cycle phases meet this.

## Structure
- Shared package adc_serial_pkg holds:
  - the DATA_W default and the CONV_CYCLES default (17 us at 50 MHz);
  - frame state encoding IDLE/SHIFT/TAIL;
  - converter state encoding READY/CONV.
- One sub-module: adc_sync_edge. It is a parameterized SYNC_STAGES synchronizer with rise and fall pulse outputs, instantiated once for adc_cs_n and once for adc_clk.
- The frame FSM, shift register, bit counter, converter FSM and down-counter are all in the top level.

## Test plan
- Reset then a full frame, with sample_in = 8'hA5 held: the shifted bits are 00000000 (power-on result). frame_done pulses once; conv_busy is high for exactly 850 cycles; result becomes 8'hA5.
- A second frame, started after conv_busy falls: the reader captures 1,0,1,0,0,1,0,1. adc_data_oe tracks cs_n with a 3-cycle lag; adc_data is 0 after the 8th fall.
- Abort: cs_n rises after 5 adc_clk falls. The required response is no frame_done, no conv_busy, result unchanged, and the next frame restarting at the MSB.
- cs_n falls 100 cycles into a conversion: conv_err sets and stays set. The frame shifts the old result. The conversion completes at cycle 850 with the originally latched sample.
- 12 adc_clk pulses inside one frame: only the first 8 falling edges shift; frame_done pulses once; adc_data stays 0 for the remainder.
- rst_n low mid-conversion, with result = 8'h3C and sample_in = 8'hFF: after one clk, all outputs are at their reset values and result is 0. No stale write occurs when the counter would have expired.
